ofs_plat_axi_mem_credit_gate: RTL
=================================

OFS_PLAT_AXI_MEM_CREDIT_GATE -- requirements
Module: ofs_plat_axi_mem_credit_gate

Interface
REQ-001 SHALL have parameter BURST_CNT_WIDTH, default 8, width of AxLEN; burst beats = len+1.
REQ-002 SHALL have parameter MAX_RD_OUTSTANDING, default 16, max accepted-but-unretired read bursts (>=1).
REQ-003 SHALL have parameter MAX_WR_OUTSTANDING, default 16, max accepted-but-unretired write bursts (>=1).
REQ-004 SHALL have ports: clk input 1, sole clock; reset input 1, synchronous, active-high.
REQ-005 SHALL have ports src_arvalid in 1, src_arready out 1, ar_len in BURST_CNT_WIDTH: source read address handshake and length.
REQ-006 SHALL have ports sink_arvalid out 1, sink_arready in 1: gated read address handshake toward sink.
REQ-007 SHALL have ports src_awvalid in 1, src_awready out 1, sink_awvalid out 1, sink_awready in 1: write address gating.
REQ-008 SHALL have ports rvalid in 1, rready in 1, rlast in 1: observed read response channel (monitor only).
REQ-009 SHALL have ports bvalid in 1, bready in 1: observed write response channel (monitor only).
REQ-010 SHALL have outputs rd_outstanding clog2(MAX_RD_OUTSTANDING+1), wr_outstanding clog2(MAX_WR_OUTSTANDING+1): live burst counts.
REQ-011 SHALL have outputs err_r_last, err_r_unexpected, err_b_unexpected 1 each: sticky protocol errors; idle out 1.

Function
REQ-012 SHALL compute rd_ok = (rd_outstanding < MAX_RD_OUTSTANDING); sink_arvalid = src_arvalid & rd_ok; src_arready = sink_arready & rd_ok (combinational, no added latency).
REQ-013 SHALL compute wr_ok/sink_awvalid/src_awready identically using wr_outstanding and MAX_WR_OUTSTANDING.
REQ-014 SHALL define AR accept = src_arvalid & src_arready; on accept push ar_len into an in-order length FIFO of depth MAX_RD_OUTSTANDING; FIFO never overflows because of REQ-012.
REQ-015 SHALL keep beat counter (BURST_CNT_WIDTH bits) for the FIFO head burst; each R handshake (rvalid & rready) with FIFO non-empty increments it.
REQ-016 SHALL on R handshake with beat == head len: retire burst -- pop FIFO, clear beat counter, decrement rd_outstanding; rlast=0 here sets err_r_last.
REQ-017 SHALL on R handshake with beat < head len: rlast=1 sets err_r_last; beat counter advances, burst not retired (no early retire on stray rlast).
REQ-018 SHALL on R handshake with FIFO empty set err_r_unexpected and change no counters.
REQ-019 SHALL on B handshake (bvalid & bready) decrement wr_outstanding; if wr_outstanding==0 set err_b_unexpected and hold count at 0.
REQ-020 SHALL, when accept and retire occur in the same cycle on one direction, leave the count unchanged and perform FIFO push and pop together (including at count==MAX, where retire frees no credit for that same cycle's gating -- gating uses registered count).
REQ-021 SHALL update rd_outstanding/wr_outstanding registered, visible the cycle after the handshake.
REQ-022 SHALL drive idle = (rd_outstanding==0) & (wr_outstanding==0), registered-count based.
REQ-023 SHALL handle len = 2**BURST_CNT_WIDTH-1 (max burst) without counter wrap before retire.
REQ-024 SHALL keep error flags set until reset; errors SHALL NOT alter gating.
REQ-025 SHALL assume in-order read responses per the single tracked stream; ID reordering is out of scope.

Reset
REQ-026 SHALL on reset clear rd_outstanding, wr_outstanding, beat counter, FIFO, and all error flags; idle=1 the cycle after reset.
REQ-027 SHALL, during reset, hold src_arready, src_awready, sink_arvalid, sink_awvalid at 0 and ignore R/B handshakes.
REQ-028 SHALL, on reset asserted mid-burst, discard all tracking state; post-reset responses of pre-reset bursts flag err_r_unexpected/err_b_unexpected.

Verification
REQ-029 MAX_RD_OUTSTANDING=2: three back-to-back ARs with sink_arready=1, no R -> first two accepted, third held (src_arready=0), rd_outstanding=2.
REQ-030 AR len=3, four R beats rlast=0,0,0,1 -> no errors, rd_outstanding 1->0 after fourth beat, idle=1.
REQ-031 AR len=1, R beats rlast=1 then 1 -> err_r_last set on beat 0; burst retires on beat 1; flag stays set.
REQ-032 At rd_outstanding=MAX, same-cycle AR offer and retiring R -> AR not accepted that cycle, accepted next cycle, count returns to MAX.
REQ-033 After reset, B handshake with wr_outstanding=0 -> err_b_unexpected=1, wr_outstanding stays 0.
REQ-034 Reset asserted with 2 reads pending -> counts 0, FIFO empty, flags 0; then R handshake -> err_r_unexpected=1.

Source files
------------

// File: rtl/ofs_plat_axi_mem_credit_gate.sv
// Limits accepted-but-unretired AXI read/write bursts to a fixed credit budget,
// and tracks read burst lengths to retire bursts and flag response protocol errors.
module ofs_plat_axi_mem_credit_gate #(
    parameter  int BURST_CNT_WIDTH    = 8,
    parameter  int MAX_RD_OUTSTANDING = 16,
    parameter  int MAX_WR_OUTSTANDING = 16,
    localparam int RD_CNT_W           = $clog2(MAX_RD_OUTSTANDING + 1),
    localparam int WR_CNT_W           = $clog2(MAX_WR_OUTSTANDING + 1)
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       src_arvalid,
    output logic                       src_arready,
    input  logic [BURST_CNT_WIDTH-1:0] ar_len,
    output logic                       sink_arvalid,
    input  logic                       sink_arready,

    input  logic                       src_awvalid,
    output logic                       src_awready,
    output logic                       sink_awvalid,
    input  logic                       sink_awready,

    input  logic                       rvalid,
    input  logic                       rready,
    input  logic                       rlast,
    input  logic                       bvalid,
    input  logic                       bready,

    output logic [RD_CNT_W-1:0]        rd_outstanding,
    output logic [WR_CNT_W-1:0]        wr_outstanding,
    output logic                       err_r_last,
    output logic                       err_r_unexpected,
    output logic                       err_b_unexpected,
    output logic                       idle
);

    localparam int PTR_W = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
    localparam logic [RD_CNT_W-1:0] RD_MAX  = RD_CNT_W'(MAX_RD_OUTSTANDING);
    localparam logic [WR_CNT_W-1:0] WR_MAX  = WR_CNT_W'(MAX_WR_OUTSTANDING);
    localparam logic [PTR_W-1:0]    PTR_TOP = PTR_W'(MAX_RD_OUTSTANDING - 1);

    logic [RD_CNT_W-1:0]        rd_cnt_q, rd_cnt_d;
    logic [WR_CNT_W-1:0]        wr_cnt_q, wr_cnt_d;
    logic [PTR_W-1:0]           push_ptr_q, push_ptr_d;
    logic [PTR_W-1:0]           pop_ptr_q, pop_ptr_d;
    logic [BURST_CNT_WIDTH-1:0] beat_q, beat_d;
    logic                       err_r_last_q, err_r_last_d;
    logic                       err_r_unexp_q, err_r_unexp_d;
    logic                       err_b_unexp_q, err_b_unexp_d;
    logic [BURST_CNT_WIDTH-1:0] len_mem [MAX_RD_OUTSTANDING];

    logic rd_ok, wr_ok, ar_accept, aw_accept;
    logic rd_empty, r_track, head_last, rd_retire;
    logic b_hs, wr_retire;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_TOP) ? '0 : p + 1'b1;
    endfunction

    // Gating looks only at the registered counts, so a same-cycle retire frees no credit.
    assign rd_ok        = !reset && (rd_cnt_q < RD_MAX);
    assign wr_ok        = !reset && (wr_cnt_q < WR_MAX);
    assign sink_arvalid = src_arvalid & rd_ok;
    assign src_arready  = sink_arready & rd_ok;
    assign sink_awvalid = src_awvalid & wr_ok;
    assign src_awready  = sink_awready & wr_ok;
    assign ar_accept    = src_arvalid & src_arready;
    assign aw_accept    = src_awvalid & src_awready;

    // The FIFO occupancy is exactly the outstanding read count.
    assign rd_empty  = (rd_cnt_q == '0);
    assign r_track   = rvalid & rready & !rd_empty;
    assign head_last = (beat_q == len_mem[pop_ptr_q]);
    assign rd_retire = r_track & head_last;
    assign b_hs      = bvalid & bready;
    assign wr_retire = b_hs & (wr_cnt_q != '0);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
        rd_cnt_d      = rd_cnt_q;
        wr_cnt_d      = wr_cnt_q;
        push_ptr_d    = push_ptr_q;
        pop_ptr_d     = pop_ptr_q;
        beat_d        = beat_q;
        err_r_last_d  = err_r_last_q;
        err_r_unexp_d = err_r_unexp_q;
        err_b_unexp_d = err_b_unexp_q;

        if (ar_accept && !rd_retire)      rd_cnt_d = rd_cnt_q + 1'b1;
        else if (!ar_accept && rd_retire) rd_cnt_d = rd_cnt_q - 1'b1;
        if (aw_accept && !wr_retire)      wr_cnt_d = wr_cnt_q + 1'b1;
        else if (!aw_accept && wr_retire) wr_cnt_d = wr_cnt_q - 1'b1;

        if (ar_accept) push_ptr_d = next_ptr(push_ptr_q);
        if (rd_retire) pop_ptr_d  = next_ptr(pop_ptr_q);

        // A stray rlast only flags; the burst still retires on its final counted beat.
        if (r_track) begin
            beat_d = head_last ? '0 : beat_q + 1'b1;
            if (head_last != rlast) err_r_last_d = 1'b1;
        end
        if (rvalid && rready && rd_empty) err_r_unexp_d = 1'b1;
        if (b_hs && (wr_cnt_q == '0))     err_b_unexp_d = 1'b1;
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt_q      <= '0;
            wr_cnt_q      <= '0;
            push_ptr_q    <= '0;
            pop_ptr_q     <= '0;
            beat_q        <= '0;
            err_r_last_q  <= 1'b0;
            err_r_unexp_q <= 1'b0;
            err_b_unexp_q <= 1'b0;
        end else begin
            rd_cnt_q      <= rd_cnt_d;
            wr_cnt_q      <= wr_cnt_d;
            push_ptr_q    <= push_ptr_d;
            pop_ptr_q     <= pop_ptr_d;
            beat_q        <= beat_d;
            err_r_last_q  <= err_r_last_d;
            err_r_unexp_q <= err_r_unexp_d;
            err_b_unexp_q <= err_b_unexp_d;
        end
    end

    // NOTE: the length storage has no reset; entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (ar_accept) len_mem[push_ptr_q] <= ar_len;
    end

    assign rd_outstanding   = rd_cnt_q;
    assign wr_outstanding   = wr_cnt_q;
    assign err_r_last       = err_r_last_q;
    assign err_r_unexpected = err_r_unexp_q;
    assign err_b_unexpected = err_b_unexp_q;
    assign idle             = rd_empty && (wr_cnt_q == '0);

endmodule
